// File: rtl/fft_r2_first_stage.sv
// fft_r2_first_stage: streaming radix-2 DIT stage-0 butterfly (twiddle = 1) with output framing.
module fft_r2_first_stage #(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    input  logic          scale_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    input  logic          ready_i
);
    localparam int HW = DW / 2;
    localparam logic [1:0] WAIT_A    = 2'd0;
    localparam logic [1:0] WAIT_B    = 2'd1;
    localparam logic [1:0] EMIT_SUM  = 2'd2;
    localparam logic [1:0] EMIT_DIFF = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] a_q, a_d, sum_q, sum_d, diff_q, diff_d;
    logic [K-1:0]  cnt_q, cnt_d;
    logic          in_xfer, out_xfer;

    // Overflow shows up as disagreement between the guard bit and the HW-bit sign.
    function automatic logic [HW-1:0] fix(input logic [HW:0] v, input logic sc);
        return sc ? v[HW:1] : (v[HW] ^ v[HW-1]) ? {v[HW], {(HW-1){~v[HW]}}} : v[HW-1:0];
    endfunction

    function automatic logic [DW-1:0] bfly(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic sc, input logic sub);
        logic [HW:0] ar, ai, br, bi, r, i;
        ar = {a[DW-1], a[DW-1:HW]};
        ai = {a[HW-1], a[HW-1:0]};
        br = {b[DW-1], b[DW-1:HW]};
        bi = {b[HW-1], b[HW-1:0]};
        r  = sub ? ar - br : ar + br;
        i  = sub ? ai - bi : ai + bi;
        return {fix(r, sc), fix(i, sc)};
    endfunction

    assign ready_o  = ~state_q[1];
    assign valid_o  = state_q[1];
    assign data_o   = !valid_o ? '0 : state_q[0] ? diff_q : sum_q;
    assign last_o   = valid_o && (cnt_q == {K{1'b1}});
    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sum_d   = sum_q;
        diff_d  = diff_q;
        cnt_d   = out_xfer ? cnt_q + K'(1) : cnt_q;
        case (state_q)
            WAIT_A: if (in_xfer) begin
                a_d     = data_i;
                state_d = WAIT_B;
            end
            WAIT_B: if (in_xfer) begin
                sum_d   = bfly(a_q, data_i, scale_i, 1'b0);
                diff_d  = bfly(a_q, data_i, scale_i, 1'b1);
                state_d = EMIT_SUM;
            end
            EMIT_SUM:  if (out_xfer) state_d = EMIT_DIFF;
            default:   if (out_xfer) state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            sum_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sum_q   <= sum_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fft_r2_first_stage.sv
// tb_fft_r2_first_stage: scoreboard bench for the stage-0 butterfly, K=2 to exercise frame wrap.
module tb_fft_r2_first_stage;
    localparam int K  = 2;
    localparam int DW = 32;

    logic          clk_i = 0, rst_ni = 0, valid_i = 0, scale_i = 0, ready_i = 1;
    logic [DW-1:0] data_i = '0;
    logic          ready_o, valid_o, last_o;
    logic [DW-1:0] data_o;

    int            n_tests = 0, n_fail = 0, out_cnt = 0;
    bit            tog = 0;
    logic [DW-1:0] exp_q[$];

    fft_r2_first_stage #(.K(K), .DW(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .scale_i(scale_i), .valid_o(valid_o), .data_o(data_o),
        .last_o(last_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int re, input int im);
        logic [31:0] r, i;
        r = re;
        i = im;
        return {r[15:0], i[15:0]};
    endfunction

    function automatic int half(input int x, input bit sc);
        if (sc) return x >>> 1;
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input bit sc, input bit sub);
        int ar, ai, br, bi;
        ar = int'($signed(a[31:16]));
        ai = int'($signed(a[15:0]));
        br = int'($signed(b[31:16]));
        bi = int'($signed(b[15:0]));
        return sub ? pk(half(ar - br, sc), half(ai - bi, sc))
                   : pk(half(ar + br, sc), half(ai + bi, sc));
    endfunction

    task automatic send(input logic [31:0] d, input bit sc);
        int n = 0;
        valid_i = 1;
        data_i  = d;
        scale_i = sc;
        while (!ready_o && n < 200) begin
            @(posedge clk_i);
            #1 n++;
        end
        if (n >= 200) chk("send_timeout", 32'(n), 0);
        @(posedge clk_i);
        #1 valid_i = 0;
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input bit sc);
        send(a, sc);
        exp_q.push_back(model(a, b, sc, 0));
        exp_q.push_back(model(a, b, sc, 1));
        send(b, sc);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk_i);
            #1 n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    // Inputs change only just after posedge, so at negedge valid_o && ready_i predicts the transfer.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_out", data_o, 32'hxxxxxxxx);
            else chk("data", data_o, exp_q.pop_front());
            chk("last", 32'(last_o), 32'((out_cnt % 4) == 3));
            out_cnt++;
        end
    end

    always @(posedge clk_i) if (tog) #1 ready_i = 1'($urandom_range(0, 1));

    initial begin
        logic [31:0] held;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_last", 32'(last_o), 0);
        chk("rst_data", data_o, 0);
        rst_ni = 1;
        @(posedge clk_i);
        #1 chk("rst_ready", 32'(ready_o), 1);

        send_pair(pk(100, -50), pk(20, 30), 0);
        chk("latency_valid", 32'(valid_o), 1);
        chk("basic_sum", data_o, pk(120, -20));
        drain();

        send_pair(pk(32767, -32768), pk(1, 1), 0);
        send_pair(pk(-32768, 0), pk(1, 0), 0);
        drain();

        send_pair(pk(32767, -32768), pk(32767, -32768), 1);
        send_pair(pk(-3, 0), pk(0, 0), 1);
        scale_i = 0;
        drain();

        ready_i = 0;
        send_pair(pk(1000, 2000), pk(-300, 400), 0);
        held = data_o;
        valid_i = 1;
        data_i = pk(5, 6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            chk("bp_valid", 32'(valid_o), 1);
            chk("bp_data", data_o, held);
            chk("bp_ready", 32'(ready_o), 0);
        end
        valid_i = 0;
        ready_i = 1;
        send_pair(pk(5, 6), pk(7, 8), 0);
        drain();

        tog = 1;
        for (int i = 0; i < 6; i++)
            send_pair(pk($urandom_range(0, 60000) - 30000, i), pk(i * 3, -i), 1'(i));
        drain();
        tog = 0;
        #1 ready_i = 1;
        drain();

        send(pk(3, 3), 0);
        rst_ni = 0;
        #1;
        exp_q.delete();
        out_cnt = 0;
        repeat (2) begin
            @(posedge clk_i);
            #1;
            chk("mid_rst_valid", 32'(valid_o), 0);
            chk("mid_rst_last", 32'(last_o), 0);
        end
        rst_ni = 1;
        send_pair(pk(7, 0), pk(9, 0), 0);
        chk("mid_rst_sum", data_o, pk(16, 0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
